// File: rtl/pc_source_seq_if.sv
// Control bundle between the OTTER sequencer and the IR/branch-compare/PC/memory/regfile datapath.
// master: the sequencer side that drives the strobes; slave: the datapath side.
interface pc_source_seq_if;
    logic       intr;
    logic       mie;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       is_mret;
    logic       br_eq;
    logic       br_lt;
    logic       br_ltu;
    logic       pc_write;
    logic [2:0] pc_source;
    logic       ir_write;
    logic       mem_rden1;
    logic       mem_rden2;
    logic       mem_we2;
    logic       reg_write;
    logic       csr_we;
    logic       int_taken;
    logic       mret_exec;
    logic [2:0] state;

    modport master (
        input  intr, mie, opcode, func3, is_mret, br_eq, br_lt, br_ltu,
        output pc_write, pc_source, ir_write, mem_rden1, mem_rden2, mem_we2,
               reg_write, csr_we, int_taken, mret_exec, state
    );

    modport slave (
        output intr, mie, opcode, func3, is_mret, br_eq, br_lt, br_ltu,
        input  pc_write, pc_source, ir_write, mem_rden1, mem_rden2, mem_we2,
               reg_write, csr_we, int_taken, mret_exec, state
    );
endinterface

// File: rtl/pc_source_seq.sv
// OTTER RV32I multi-cycle sequencer: fetch/exec/writeback stepping and PC source decode.
// Define PC_SEQ_INTR_EN to build the interrupt check and the one-cycle trap-entry state.
module pc_source_seq (
    input logic              clk,
    input logic              rst_n,
    pc_source_seq_if.master  bus
);
    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StFetch = 3'd1,
        StExec  = 3'd2,
        StWb    = 3'd3,
        StIntr  = 3'd4
    } state_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [2:0] SrcPc4    = 3'b000;
    localparam logic [2:0] SrcJalr   = 3'b001;
    localparam logic [2:0] SrcBranch = 3'b010;
    localparam logic [2:0] SrcJal    = 3'b011;
    localparam logic [2:0] SrcMtvec  = 3'b100;
    localparam logic [2:0] SrcMepc   = 3'b101;

    state_e     state_q, state_d;
    state_e     after_instr;
    logic       br_taken;
    logic       pc_write, ir_write, mem_rden1, mem_rden2, mem_we2;
    logic       reg_write, csr_we, int_taken, mret_exec;
    logic [2:0] pc_source;

    // Interrupts are only honoured once the current instruction has fully retired.
`ifdef PC_SEQ_INTR_EN
    assign after_instr = (bus.intr && bus.mie) ? StIntr : StFetch;
`else
    logic unused_intr;
    assign unused_intr = bus.intr ^ bus.mie;
    assign after_instr = StFetch;
`endif

    always_comb begin
        br_taken = 1'b0;
        unique case (bus.func3)
            3'b000:  br_taken = bus.br_eq;
            3'b001:  br_taken = !bus.br_eq;
            3'b100:  br_taken = bus.br_lt;
            3'b101:  br_taken = !bus.br_lt;
            3'b110:  br_taken = bus.br_ltu;
            3'b111:  br_taken = !bus.br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StInit;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_write  = 1'b0;
        pc_source = SrcPc4;
        ir_write  = 1'b0;
        mem_rden1 = 1'b0;
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        reg_write = 1'b0;
        csr_we    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        unique case (state_q)
            StInit: state_d = StFetch;
            StFetch: begin
                mem_rden1 = 1'b1;
                ir_write  = 1'b1;
                state_d   = StExec;
            end
            StExec: begin
                pc_write = 1'b1;
                state_d  = after_instr;
                unique case (bus.opcode)
                    OpLui, OpAuipc, OpReg, OpImm: reg_write = 1'b1;
                    OpJal: begin
                        reg_write = 1'b1;
                        pc_source = SrcJal;
                    end
                    OpJalr: begin
                        reg_write = 1'b1;
                        pc_source = SrcJalr;
                    end
                    OpBranch: pc_source = br_taken ? SrcBranch : SrcPc4;
                    OpStore:  mem_we2 = 1'b1;
                    OpLoad: begin
                        pc_write  = 1'b0;
                        mem_rden2 = 1'b1;
                        state_d   = StWb;
                    end
                    OpSystem: begin
                        if (bus.func3 != 3'b000) begin
                            csr_we    = 1'b1;
                            reg_write = 1'b1;
                        end else if (bus.is_mret) begin
                            pc_source = SrcMepc;
                            mret_exec = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            StWb: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = after_instr;
            end
`ifdef PC_SEQ_INTR_EN
            StIntr: begin
                pc_write  = 1'b1;
                pc_source = SrcMtvec;
                int_taken = 1'b1;
                state_d   = StFetch;
            end
`endif
            default: state_d = StInit;
        endcase
    end

    assign bus.pc_write  = pc_write;
    assign bus.pc_source = pc_source;
    assign bus.ir_write  = ir_write;
    assign bus.mem_rden1 = mem_rden1;
    assign bus.mem_rden2 = mem_rden2;
    assign bus.mem_we2   = mem_we2;
    assign bus.reg_write = reg_write;
    assign bus.csr_we    = csr_we;
    assign bus.int_taken = int_taken;
    assign bus.mret_exec = mret_exec;
    assign bus.state     = state_q;
endmodule
